// File: rtl/seq_stream_ctrl.sv
// Purpose : serialize valid/ready words MSB-first onto a bit stream and count pattern hits.
// Latency : first bit the cycle after the handshake; hit one cycle after the last pattern bit.
// Backpr. : in_ready only in IDLE or on the last bit of a word; back-to-back words leave no gap.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_ready word input handshake (W bits, MSB sent first)
//   cfg_we/cfg_pattern/cfg_overlap  pattern and overlap-mode load, taken only in IDLE
//   clr_cnt                   synchronous clear of hit_count (wins over a same-edge hit)
//   ser_bit/ser_valid         serial stream towards the detector
//   hit/hit_count             one-cycle match pulse and saturating match count
//   busy                      high while a word is being shifted out
//
// W and PAT_W must both be at least 2.

module seq_stream_ctrl #(
  parameter int              W       = 8,
  parameter int              PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10000,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int FW = $clog2(PAT_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [W-1:0]       shreg;
  logic [BW-1:0]      bit_cnt;
  logic [PAT_W-1:0]   pat_q;
  logic               ovl_q;
  // Only the PAT_W-1 most recent bits need storing; the bit on ser_bit
  // completes the window.
  logic [PAT_W-2:0]   hist;
  logic [FW-1:0]      fill;

  logic [PAT_W-1:0]   window;
  logic [FW-1:0]      fill_inc;
  logic [FW-1:0]      fill_nxt;
  logic               match;
  logic               last_bit;

  // Match evaluation for the bit currently on ser_bit.
  always_comb begin
    window   = {hist, ser_bit};
    fill_inc = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    match    = (state == SHIFT) && (window == pat_q) && (fill_inc == FW'(PAT_W));
    // In non-overlap mode the next match must be built from fresh bits only.
    fill_nxt = (match && !ovl_q) ? '0 : fill_inc;
    last_bit = (bit_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      pat_q     <= PATTERN;
      ovl_q     <= OVERLAP;
      hist      <= '0;
      fill      <= '0;
      in_ready  <= 1'b1;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      hit       <= 1'b0;
      hit_count <= '0;
    end else begin
      hit <= 1'b0;

      case (state)
        IDLE: begin
          // Config lands before the word on a shared cycle, so that word
          // is already matched against the new pattern.
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            ovl_q <= cfg_overlap;
            fill  <= '0;
          end
          if (in_valid) begin
            state     <= SHIFT;
            shreg     <= in_data;
            bit_cnt   <= BW'(W - 1);
            ser_bit   <= in_data[W-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
          end
        end

        SHIFT: begin
          hist <= window[PAT_W-2:0];
          fill <= fill_nxt;
          hit  <= match;

          if (last_bit) begin
            if (in_valid) begin
              // Reload on the last bit keeps the stream gap-free.
              shreg    <= in_data;
              bit_cnt  <= BW'(W - 1);
              ser_bit  <= in_data[W-1];
              in_ready <= 1'b0;
            end else begin
              state     <= IDLE;
              ser_bit   <= 1'b0;
              ser_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end else begin
            shreg    <= shreg << 1;
            bit_cnt  <= bit_cnt - 1'b1;
            ser_bit  <= shreg[W-2];
            // Ready goes up together with the last bit of the word.
            in_ready <= (bit_cnt == BW'(1));
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (clr_cnt) begin
        hit_count <= '0;
      end else if (match && !(&hit_count)) begin
        hit_count <= hit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Purpose : directed check of seq_stream_ctrl (serializer, matcher, counter).
// Latency : stimulus is cycle-stepped; outputs sampled 1 ns after each rising edge.
// Backpr. : bench honours in_ready; a second instance with CNT_W=2 shares all inputs.

module tb_seq_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       cfg_we;
  logic [4:0] cfg_pattern;
  logic       cfg_overlap;
  logic       clr_cnt;

  logic       in_ready, ser_bit, ser_valid, hit, busy;
  logic [7:0] hit_count;
  logic       in_ready2, ser_bit2, ser_valid2, hit2, busy2;
  logic [1:0] hit_count2;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] hit_m, hit2_m, vld_m, rdy_m, bit_m, busy_m;
  int          cnt_a  [64];
  int          cnt2_a [64];
  logic [7:0]  words  [8];

  always #5 clk = ~clk;

  seq_stream_ctrl #(
    .W(8), .PAT_W(5), .PATTERN(5'b10000), .OVERLAP(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt),
    .ser_bit(ser_bit), .ser_valid(ser_valid),
    .hit(hit), .hit_count(hit_count), .busy(busy)
  );

  seq_stream_ctrl #(
    .W(8), .PAT_W(5), .PATTERN(5'b10000), .OVERLAP(1'b1), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .clr_cnt(clr_cnt),
    .ser_bit(ser_bit2), .ser_valid(ser_valid2),
    .hit(hit2), .hit_count(hit_count2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cfg_we   = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offers nw words from words[] back-to-back and records ncyc cycles.
  // Cycle index c=0 is the cycle after the first handshake edge.
  // cfg_at=-1 pulses cfg_we together with the first handshake; cfg_at=c
  // and clr_at=c assert the strobe during cycle c (sampled at its end).
  task automatic stream(input int nw, input int ncyc, input int cfg_at, input int clr_at);
    int   wi;
    logic hs;
    wi     = 0;
    hit_m  = '0; hit2_m = '0; vld_m = '0; rdy_m = '0; bit_m = '0; busy_m = '0;
    in_valid = 1'b1;
    in_data  = words[0];
    cfg_we   = (cfg_at == -1);
    clr_cnt  = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      hs = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        wi++;
        if (wi < nw) in_data = words[wi];
        else         in_valid = 1'b0;
      end
      hit_m[c]  = hit;
      hit2_m[c] = hit2;
      vld_m[c]  = ser_valid;
      rdy_m[c]  = in_ready;
      bit_m[c]  = ser_bit;
      busy_m[c] = busy;
      cnt_a[c]  = int'(hit_count);
      cnt2_a[c] = int'(hit_count2);
      cfg_we    = (c == cfg_at);
      clr_cnt   = (c == clr_at);
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_pattern = 5'b00000;
    cfg_overlap = 1'b0;
    do_reset();

    // Reset state
    chk("rst_in_ready",  64'(in_ready),   64'h1);
    chk("rst_ser_valid", 64'(ser_valid),  64'h0);
    chk("rst_ser_bit",   64'(ser_bit),    64'h0);
    chk("rst_hit",       64'(hit),        64'h0);
    chk("rst_count",     64'(hit_count),  64'h0);
    chk("rst_busy",      64'(busy),       64'h0);
    chk("rst2_outs",     64'({in_ready2, ser_valid2, ser_bit2, hit2, busy2, hit_count2}),
        64'b1000000);

    // Default pattern 10000, word 1000_0100: hit after 5th bit
    words[0] = 8'h84;
    stream(1, 10, -9, -9);
    chk("t1_hit",   64'(hit_m[9:0]),  64'h020);
    chk("t1_bits",  64'(bit_m[9:0]),  64'h021);
    chk("t1_busy",  64'(busy_m[9:0]), 64'h0FF);
    chk("t1_vld",   64'(vld_m[9:0]),  64'h0FF);
    chk("t1_rdy",   64'(rdy_m[9:0]),  64'h380);
    chk("t1_count", 64'(cnt_a[9]),    64'd1);

    // Cross-word match: 01 then 00
    do_reset();
    words[0] = 8'h01;
    words[1] = 8'h00;
    stream(2, 18, -9, -9);
    chk("t2_vld",   64'(vld_m[16:0]), 64'h0FFFF);
    chk("t2_rdy",   64'(rdy_m[15:0]), 64'h8080);
    chk("t2_hit",   64'(hit_m[17:0]), 64'h01000);
    chk("t2_count", 64'(cnt_a[17]),   64'd1);

    // Pattern 10101 on 1010_1010, overlap on
    do_reset();
    cfg_pattern = 5'b10101;
    cfg_overlap = 1'b1;
    words[0] = 8'hAA;
    stream(1, 10, -1, -9);
    chk("t3o_hit",   64'(hit_m[9:0]), 64'h0A0);
    chk("t3o_count", 64'(cnt_a[9]),   64'd2);

    // Same, overlap off
    do_reset();
    cfg_overlap = 1'b0;
    stream(1, 10, -1, -9);
    chk("t3n_hit",   64'(hit_m[9:0]), 64'h020);
    chk("t3n_count", 64'(cnt_a[9]),   64'd1);

    // cfg_we mid-word is ignored; later word still matches 10000
    do_reset();
    cfg_pattern = 5'b11111;
    cfg_overlap = 1'b0;
    words[0] = 8'h84;
    stream(1, 10, 2, -9);
    chk("t4a_hit",   64'(hit_m[9:0]), 64'h020);
    chk("t4a_count", 64'(cnt_a[9]),   64'd1);
    words[0] = 8'hF8;
    words[1] = 8'h00;
    stream(2, 18, -9, -9);
    chk("t4b_hit",   64'(hit_m[17:0]), 64'h00200);
    chk("t4b_count", 64'(cnt_a[17]),   64'd2);

    // Saturation with CNT_W=2, then clear coincident with a hit
    do_reset();
    for (int i = 0; i < 4; i++) words[i] = 8'h84;
    stream(4, 34, -9, -9);
    chk("t5_hit",      64'(hit_m[33:0]),  64'h020202020);
    chk("t5_hit2",     64'(hit2_m[33:0]), 64'h020202020);
    chk("t5_cnt2_b13", 64'(cnt2_a[13]),   64'd2);
    chk("t5_cnt2_b21", 64'(cnt2_a[21]),   64'd3);
    chk("t5_cnt2_end", 64'(cnt2_a[33]),   64'd3);
    chk("t5_cnt_end",  64'(cnt_a[33]),    64'd4);
    stream(1, 10, -9, 4);
    chk("t5c_hit",   64'(hit_m[5]),  64'h1);
    chk("t5c_cnt2",  64'(cnt2_a[5]), 64'd0);
    chk("t5c_cnt",   64'(cnt_a[5]),  64'd0);
    chk("t5c_cnt9",  64'(cnt_a[9]),  64'd0);

    // Reset during bit 3 of a word; history must not survive
    do_reset();
    words[0] = 8'h84;
    stream(1, 10, -9, -9);
    chk("t6_pre_count", 64'(cnt_a[9]), 64'd1);
    in_valid = 1'b1;
    in_data  = 8'h84;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t6_busy_mid", 64'(busy), 64'h1);
    rst = 1'b0;
    #1;
    chk("t6_rst_outs", 64'({in_ready, ser_valid, ser_bit, hit, busy}), 64'b10000);
    chk("t6_rst_count", 64'(hit_count), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    words[0] = 8'h08;
    stream(1, 10, -9, -9);
    chk("t6_hit",   64'(hit_m[9:0]), 64'h000);
    chk("t6_count", 64'(cnt_a[9]),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
